// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings and state type for the serial ALU sequencer
package alu_pkg;

  localparam logic [1:0] SEL_BUF  = 2'b00;
  localparam logic [1:0] SEL_NOT  = 2'b01;
  localparam logic [1:0] SEL_XOR  = 2'b10;
  localparam logic [1:0] SEL_XNOR = 2'b11;
  localparam logic [1:0] SEL_ADD  = 2'b00;
  localparam logic [1:0] SEL_NADD = 2'b01;

  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Only ADD and NADD track a carry; mode 1 with select 1x is passed through raw.
  function automatic logic is_arith(input logic [1:0] sel, input logic mode);
    return (mode == MODE_ARITH) && !sel[1];
  endfunction

endpackage

// File: rtl/alu_carry_cell.sv
// rtl/alu_carry_cell.sv - corrects the slice's truncated sum bit and computes the next carry
module alu_carry_cell
  import alu_pkg::*;
(
  input  logic       alu_out,
  input  logic       a_bit,
  input  logic       carry,
  input  logic [1:0] sel,
  input  logic       mode,
  output logic       bit_out,
  output logic       carry_next
);

  logic arith;
  logic a_eff;
  logic b_eff;

  // The slice reports a'^b, so b is recovered from it rather than routed in.
  always_comb begin
    arith      = is_arith(sel, mode);
    a_eff      = (sel == SEL_NADD) ? ~a_bit : a_bit;
    b_eff      = alu_out ^ a_eff;
    bit_out    = alu_out;
    carry_next = 1'b0;
    if (arith) begin
      bit_out    = alu_out ^ carry;
      carry_next = (a_eff & b_eff) | (carry & alu_out);
    end
  end

endmodule

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - feeds a 1-bit ALU slice LSB-first and assembles a WIDTH-bit result
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op_select,
  input  logic             op_mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             alu_out,
  output logic [1:0]       alu_select,
  output logic             alu_mode,
  output logic             alu_a,
  output logic             alu_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   opa_sr;
  logic [WIDTH-1:0]   opb_sr;
  logic [1:0]         sel_q;
  logic               mode_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   result_q;
  logic               carry_out_q;
  logic               last_bit;
  logic               bit_fix;
  logic               carry_nxt;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  alu_carry_cell u_carry (
    .alu_out    (alu_out),
    .a_bit      (opa_sr[0]),
    .carry      (carry_q),
    .sel        (sel_q),
    .mode       (mode_q),
    .bit_out    (bit_fix),
    .carry_next (carry_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // carry_out is captured on the final shift so it is valid alongside done.
  always_ff @(posedge clk) begin
    if (reset) begin
      opa_sr      <= '0;
      opb_sr      <= '0;
      sel_q       <= 2'b00;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      cnt         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa_sr      <= op_a;
            opb_sr      <= op_b;
            sel_q       <= op_select;
            mode_q      <= op_mode;
            carry_q     <= 1'b0;
            cnt         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
          end
        end
        SHIFT: begin
          result_q <= {bit_fix, result_q[WIDTH-1:1]};
          opa_sr   <= opa_sr >> 1;
          opb_sr   <= opb_sr >> 1;
          carry_q  <= carry_nxt;
          cnt      <= cnt + CNT_W'(1);
          if (last_bit) carry_out_q <= carry_nxt;
        end
        default: ;
      endcase
    end
  end

  assign alu_select = sel_q;
  assign alu_mode   = mode_q;
  assign alu_a      = opa_sr[0];
  assign alu_b      = opb_sr[0];
  assign result     = result_q;
  assign carry_out  = carry_out_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb/tb_alu_serial_seq.sv - directed vector bench for alu_serial_seq with a behavioural 1-bit slice
module tb_alu_serial_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       op_select;
  logic             op_mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             alu_out;
  logic [1:0]       alu_select;
  logic             alu_mode;
  logic             alu_a;
  logic             alu_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  int pass_cnt;
  int total_cnt;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_select  (op_select),
    .op_mode    (op_mode),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_out    (alu_out),
    .alu_select (alu_select),
    .alu_mode   (alu_mode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out)
  );

  // 1-bit slice: arithmetic add is truncated, reserved codes output A^B.
  always_comb begin
    case ({alu_mode, alu_select})
      3'b000:  alu_out = alu_a;
      3'b001:  alu_out = ~alu_a;
      3'b010:  alu_out = alu_a ^ alu_b;
      3'b011:  alu_out = ~(alu_a ^ alu_b);
      3'b100:  alu_out = alu_a ^ alu_b;
      3'b101:  alu_out = ~alu_a ^ alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       sel;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_res;
    logic             exp_co;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drives a start pulse at a negedge, then samples n negedges; optionally injects a second start.
  task automatic run_op(input logic [1:0] sel, input logic mode,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int n, input int inject_at,
                        output int done_cnt, output int done_at, output int busy_cnt,
                        output logic [WIDTH-1:0] res, output logic co);
    done_cnt = 0;
    done_at  = -1;
    busy_cnt = 0;
    res      = '0;
    co       = 1'b0;
    @(negedge clk);
    op_select = sel;
    op_mode   = mode;
    op_a      = a;
    op_b      = b;
    start     = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = i;
          res     = result;
          co      = carry_out;
        end
      end
      if (busy) busy_cnt++;
      start = 1'b0;
      if (i == inject_at) begin
        op_select = 2'b10;
        op_mode   = 1'b0;
        op_a      = 8'hFF;
        op_b      = 8'h0F;
        start     = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int dc, da, bc;
    logic [WIDTH-1:0] r;
    logic c;
    int done_idx[$];
    int done_cycles;

    pass_cnt  = 0;
    total_cnt = 0;
    op_select = 2'b00;
    op_mode   = 1'b0;
    op_a      = '0;
    op_b      = '0;

    vecs[0] = '{2'b00, 1'b1, 8'h5A, 8'h33, 8'h8D, 1'b0};
    vecs[1] = '{2'b00, 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{2'b01, 1'b1, 8'h0F, 8'h01, 8'hF1, 1'b0};
    vecs[3] = '{2'b01, 1'b1, 8'h00, 8'h01, 8'h00, 1'b1};
    vecs[4] = '{2'b00, 1'b0, 8'hA5, 8'h3C, 8'hA5, 1'b0};
    vecs[5] = '{2'b01, 1'b0, 8'hA5, 8'h3C, 8'h5A, 1'b0};
    vecs[6] = '{2'b10, 1'b0, 8'hA5, 8'h3C, 8'h99, 1'b0};
    vecs[7] = '{2'b11, 1'b0, 8'hA5, 8'h3C, 8'h66, 1'b0};
    vecs[8] = '{2'b10, 1'b1, 8'hFF, 8'h01, 8'hFE, 1'b0};

    // Reset held together with start: reset must win.
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry_out", 32'(carry_out), 32'd0);
    chk("rst_alu_sel", 32'(alu_select), 32'd0);
    chk("rst_alu_mode", 32'(alu_mode), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_start", 32'(busy), 32'd0);

    for (int v = 0; v < 9; v++) begin
      run_op(vecs[v].sel, vecs[v].mode, vecs[v].a, vecs[v].b, 12, -1, dc, da, bc, r, c);
      chk($sformatf("v%0d_latency", v), 32'(da), 32'(WIDTH + 1));
      chk($sformatf("v%0d_done_cnt", v), 32'(dc), 32'd1);
      chk($sformatf("v%0d_result", v), 32'(r), 32'(vecs[v].exp_res));
      chk($sformatf("v%0d_carry_out", v), 32'(c), 32'(vecs[v].exp_co));
      chk($sformatf("v%0d_busy_cycles", v), 32'(bc), 32'(WIDTH + 1));
    end
    chk("result_held", 32'(result), 32'h00FE);

    // Second start while busy is ignored.
    run_op(2'b00, 1'b1, 8'h5A, 8'h33, 14, 3, dc, da, bc, r, c);
    chk("ign_done_cnt", 32'(dc), 32'd1);
    chk("ign_result", 32'(r), 32'h008D);
    chk("ign_latency", 32'(da), 32'(WIDTH + 1));
    chk("ign_busy_cycles", 32'(bc), 32'(WIDTH + 1));

    // Reset during SHIFT with counter at 4.
    @(negedge clk);
    op_select = 2'b00;
    op_mode   = 1'b1;
    op_a      = 8'hFF;
    op_b      = 8'h01;
    start     = 1'b1;
    dc = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dc++;
      if (i == 5) reset = 1'b1;
      if (i == 6) begin
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_carry_out", 32'(carry_out), 32'd0);
        reset = 1'b0;
      end
    end
    chk("mid_rst_no_done", 32'(dc), 32'd0);
    run_op(2'b01, 1'b1, 8'h0F, 8'h01, 12, -1, dc, da, bc, r, c);
    chk("post_rst_result", 32'(r), 32'h00F1);
    chk("post_rst_latency", 32'(da), 32'(WIDTH + 1));

    // Start held high: one accepted op every WIDTH+2 cycles.
    @(negedge clk);
    op_select   = 2'b10;
    op_mode     = 1'b0;
    op_a        = 8'hA5;
    op_b        = 8'h3C;
    start       = 1'b1;
    done_cycles = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (done) begin
        done_cycles++;
        done_idx.push_back(i);
        chk($sformatf("b2b_result_%0d", i), 32'(result), 32'h0099);
      end
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(done_idx.size()), 32'd3);
    chk("b2b_done_cycles", 32'(done_cycles), 32'd3);
    if (done_idx.size() == 3) begin
      chk("b2b_first", 32'(done_idx[0]), 32'(WIDTH + 1));
      chk("b2b_period_1", 32'(done_idx[1] - done_idx[0]), 32'(WIDTH + 2));
      chk("b2b_period_2", 32'(done_idx[2] - done_idx[1]), 32'(WIDTH + 2));
    end
    repeat (12) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
